// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception/ERET sequencer: CP0 register numbers,
// FSM state encoding and the write-order walk used to skip disabled writes.
package exception_sequencer_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FLUSH    = 3'd1,
        S_W_EPC    = 3'd2,
        S_W_BADV   = 3'd3,
        S_W_CAUSE  = 3'd4,
        S_W_STATUS = 3'd5,
        S_REDIRECT = 3'd6
    } state_e;

    typedef struct packed {
        logic status;
        logic cause;
        logic badv;
        logic epc;
    } wr_en_t;

    // Next enabled write after cur in the order EPC, BadVAddr, Cause, Status;
    // disabled writes take zero cycles, so the walk jumps straight past them.
    function automatic state_e next_step(input state_e cur, input wr_en_t en);
        logic past_epc, past_badv, past_cause, past_status;
        past_epc    = cur inside {S_W_EPC, S_W_BADV, S_W_CAUSE, S_W_STATUS};
        past_badv   = cur inside {S_W_BADV, S_W_CAUSE, S_W_STATUS};
        past_cause  = cur inside {S_W_CAUSE, S_W_STATUS};
        past_status = (cur == S_W_STATUS);
        if (!past_epc && en.epc)              next_step = S_W_EPC;
        else if (!past_badv && en.badv)       next_step = S_W_BADV;
        else if (!past_cause && en.cause)     next_step = S_W_CAUSE;
        else if (!past_status && en.status)   next_step = S_W_STATUS;
        else                                  next_step = S_REDIRECT;
    endfunction

endpackage

// File: rtl/exception_sequencer.sv
// Multi-cycle exception/ERET sequencer: flush, ordered CP0 writes over one
// shared port, then a single-cycle PC redirect. All outputs are registered.
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [4:0] REG_STATUS   = CP0_REG_STATUS,
    parameter logic [4:0] REG_CAUSE    = CP0_REG_CAUSE,
    parameter logic [4:0] REG_EPC      = CP0_REG_EPC,
    parameter logic [4:0] REG_BADVADDR = CP0_REG_BADVADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic        we_status,
    input  logic        we_cause,
    input  logic        we_epc,
    input  logic        we_badvaddr,
    input  logic        inc_epc,
    input  logic [31:0] exc_pc,
    input  logic [31:0] bad_vaddr,
    input  logic [31:0] new_status,
    input  logic [31:0] new_cause,
    input  logic [31:0] etarget,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_epc,
    input  logic        pipe_empty,
    output logic        busy,
    output logic        flush,
    output logic        cp0_we,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        pc_we,
    output logic [31:0] pc_target
);

    state_e      state_q, state_d;
    wr_en_t      en_q;
    logic [31:0] epc_val_q, badv_q, status_val_q, cause_q, target_q;

    logic        busy_q, flush_q, cp0_we_q, pc_we_q;
    logic [4:0]  cp0_waddr_q;
    logic [31:0] cp0_wdata_q, pc_target_q;

    logic accept;
    assign accept = (state_q == S_IDLE) && (exc_req || eret_req);

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (accept) state_d = S_FLUSH;
            S_FLUSH:    if (pipe_empty) state_d = next_step(S_FLUSH, en_q);
            S_W_EPC, S_W_BADV, S_W_CAUSE, S_W_STATUS:
                        state_d = next_step(state_q, en_q);
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // NOTE: outputs are decoded from state_d and registered with <=, so they are
    // valid in the same cycle the state is, with no input-to-output comb path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            en_q         <= '0;
            epc_val_q    <= '0;
            badv_q       <= '0;
            status_val_q <= '0;
            cause_q      <= '0;
            target_q     <= '0;
            busy_q       <= 1'b0;
            flush_q      <= 1'b0;
            cp0_we_q     <= 1'b0;
            cp0_waddr_q  <= '0;
            cp0_wdata_q  <= '0;
            pc_we_q      <= 1'b0;
            pc_target_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            flush_q     <= (state_d == S_FLUSH);
            cp0_we_q    <= state_d inside {S_W_EPC, S_W_BADV, S_W_CAUSE, S_W_STATUS};
            pc_we_q     <= (state_d == S_REDIRECT);
            pc_target_q <= (state_d == S_REDIRECT) ? target_q : '0;
            cp0_waddr_q <= '0;
            cp0_wdata_q <= '0;
            unique case (state_d)
                S_W_EPC:    begin cp0_waddr_q <= REG_EPC;      cp0_wdata_q <= epc_val_q;    end
                S_W_BADV:   begin cp0_waddr_q <= REG_BADVADDR; cp0_wdata_q <= badv_q;       end
                S_W_CAUSE:  begin cp0_waddr_q <= REG_CAUSE;    cp0_wdata_q <= cause_q;      end
                S_W_STATUS: begin cp0_waddr_q <= REG_STATUS;   cp0_wdata_q <= status_val_q; end
                default:    ;
            endcase

            // ERET is folded into the exception datapath at capture: Status-only
            // write of cp0_status with EXL cleared, redirect to cp0_epc.
            if (accept) begin
                badv_q    <= bad_vaddr;
                cause_q   <= new_cause;
                epc_val_q <= inc_epc ? exc_pc + 32'd4 : exc_pc;
                if (exc_req) begin
                    en_q         <= '{status: we_status, cause: we_cause,
                                      badv: we_badvaddr, epc: we_epc};
                    status_val_q <= new_status;
                    target_q     <= etarget;
                end else begin
                    en_q         <= '{status: 1'b1, cause: 1'b0, badv: 1'b0, epc: 1'b0};
                    status_val_q <= cp0_status & ~32'h0000_0002;
                    target_q     <= cp0_epc;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign flush     = flush_q;
    assign cp0_we    = cp0_we_q;
    assign cp0_waddr = cp0_waddr_q;
    assign cp0_wdata = cp0_wdata_q;
    assign pc_we     = pc_we_q;
    assign pc_target = pc_target_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Randomized bench for exception_sequencer: a transaction-level model builds the
// expected per-cycle output trace from the request and the pipe_empty pattern.
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_req, eret_req;
    logic        we_status, we_cause, we_epc, we_badvaddr, inc_epc;
    logic [31:0] exc_pc, bad_vaddr, new_status, new_cause, etarget, cp0_status, cp0_epc;
    logic        pipe_empty;
    logic        busy, flush, cp0_we, pc_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata, pc_target;

    always #5 clk = ~clk;

    exception_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .exc_req(exc_req), .eret_req(eret_req),
        .we_status(we_status), .we_cause(we_cause), .we_epc(we_epc), .we_badvaddr(we_badvaddr),
        .inc_epc(inc_epc), .exc_pc(exc_pc), .bad_vaddr(bad_vaddr),
        .new_status(new_status), .new_cause(new_cause), .etarget(etarget),
        .cp0_status(cp0_status), .cp0_epc(cp0_epc), .pipe_empty(pipe_empty),
        .busy(busy), .flush(flush), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .pc_we(pc_we), .pc_target(pc_target)
    );

    typedef struct packed {
        logic        busy;
        logic        flush;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        pc_we;
        logic [31:0] tgt;
    } obs_t;

    typedef struct {
        logic        exc, eret, en_s, en_c, en_e, en_b, inc;
        logic [31:0] pc, bad, ns, nc, et, cs, ce;
        int          k;   // FLUSH cycles that see pipe_empty low before it rises
    } req_t;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t exp_q[$];

    task automatic check(input string tag, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic fl, input logic we, input logic [4:0] a,
                                input logic [31:0] d, input logic pw, input logic [31:0] t);
        obs_t o;
        o.busy = 1'b1; o.flush = fl; o.we = we; o.addr = a; o.data = d; o.pc_we = pw; o.tgt = t;
        return o;
    endfunction

    // Write address/data and target are only meaningful while their strobe is expected.
    function automatic obs_t sample(input obs_t e);
        obs_t o;
        o.busy = busy; o.flush = flush; o.we = cp0_we; o.pc_we = pc_we;
        o.addr = e.we ? cp0_waddr : 5'd0;
        o.data = e.we ? cp0_wdata : 32'd0;
        o.tgt  = e.pc_we ? pc_target : 32'd0;
        return o;
    endfunction

    function automatic obs_t raw();
        obs_t o;
        o.busy = busy; o.flush = flush; o.we = cp0_we; o.addr = cp0_waddr;
        o.data = cp0_wdata; o.pc_we = pc_we; o.tgt = pc_target;
        return o;
    endfunction

    task automatic scramble(input bit glitch);
        exc_req     = glitch ? ($urandom_range(0, 3) == 0) : 1'b0;
        eret_req    = glitch ? ($urandom_range(0, 3) == 0) : 1'b0;
        we_status   = $urandom; we_cause = $urandom; we_epc = $urandom; we_badvaddr = $urandom;
        inc_epc     = $urandom;
        exc_pc      = $urandom; bad_vaddr = $urandom; new_status = $urandom;
        new_cause   = $urandom; etarget = $urandom; cp0_status = $urandom; cp0_epc = $urandom;
    endtask

    function automatic void build_expected(input req_t r);
        exp_q.delete();
        for (int i = 0; i <= r.k; i++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        if (r.exc) begin
            if (r.en_e) exp_q.push_back(mk(0, 1, 5'd14, r.inc ? r.pc + 32'd4 : r.pc, 0, 0));
            if (r.en_b) exp_q.push_back(mk(0, 1, 5'd8,  r.bad, 0, 0));
            if (r.en_c) exp_q.push_back(mk(0, 1, 5'd13, r.nc, 0, 0));
            if (r.en_s) exp_q.push_back(mk(0, 1, 5'd12, r.ns, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 1, r.et));
        end else begin
            exp_q.push_back(mk(0, 1, 5'd12, {r.cs[31:2], 1'b0, r.cs[0]}, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 1, r.ce));
        end
    endfunction

    // Entered and left at a negedge with the DUT idle; abort_at >= 0 asserts
    // reset after that cycle's check.
    task automatic run_txn(input req_t r, input string name, input int abort_at);
        build_expected(r);
        exc_req = r.exc; eret_req = r.eret;
        we_status = r.en_s; we_cause = r.en_c; we_epc = r.en_e; we_badvaddr = r.en_b;
        inc_epc = r.inc; exc_pc = r.pc; bad_vaddr = r.bad; new_status = r.ns;
        new_cause = r.nc; etarget = r.et; cp0_status = r.cs; cp0_epc = r.ce;
        pipe_empty = (r.k == 0) ? 1'($urandom) : 1'b0;
        @(negedge clk);
        for (int c = 0; c < exp_q.size(); c++) begin
            scramble(1);
            pipe_empty = (c >= r.k);
            check($sformatf("%s[%0d]", name, c), sample(exp_q[c]), exp_q[c]);
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({name, "_async_rst"}, raw(), '0);
                @(negedge clk);
                rst_n = 1'b1;
                scramble(0);
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    check($sformatf("%s_post_rst[%0d]", name, j), sample('0), '0);
                end
                return;
            end
            @(negedge clk);
        end
        scramble(0);
        check({name, "_idle"}, sample('0), '0);
    endtask

    function automatic req_t blank();
        req_t r;
        r.exc = 0; r.eret = 0; r.en_s = 0; r.en_c = 0; r.en_e = 0; r.en_b = 0; r.inc = 0;
        r.pc = 32'h1111_0000; r.bad = 32'hBADD_0000; r.ns = 32'h0000_0013;
        r.nc = 32'h0000_0020; r.et = 32'h8000_0080; r.cs = 32'h0; r.ce = 32'h0; r.k = 0;
        return r;
    endfunction

    initial begin
        req_t r;
        rst_n = 1'b0;
        scramble(0);
        pipe_empty = 1'b0;
        #12;
        check("reset_state", raw(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", sample('0), '0);

        r = blank(); r.exc = 1; r.inc = 1; r.pc = 32'h0040_0020;
        r.en_s = 1; r.en_c = 1; r.en_e = 1;
        run_txn(r, "syscall", -1);

        r = blank(); r.exc = 1; r.en_s = 1; r.en_c = 1; r.en_e = 1; r.en_b = 1;
        r.pc = 32'h0040_1000; r.bad = 32'h7FFF_F004; r.k = 2;
        run_txn(r, "tlb_miss", -1);

        r = blank(); r.eret = 1; r.cs = 32'h0000_FF03; r.ce = 32'h0040_0100;
        r.en_e = 1; r.en_b = 1;
        run_txn(r, "eret", -1);

        r = blank(); r.exc = 1; r.eret = 1; r.en_c = 1; r.cs = 32'hFFFF_FFFF; r.ce = 32'h1234_5678;
        run_txn(r, "exc_and_eret", -1);

        r = blank(); r.exc = 1; r.inc = 1; r.pc = 32'hFFFF_FFFC; r.en_e = 1;
        run_txn(r, "epc_wrap", -1);

        r = blank(); r.exc = 1;
        run_txn(r, "no_enables", -1);

        r = blank(); r.exc = 1; r.en_s = 1; r.en_c = 1; r.en_e = 1; r.en_b = 1;
        run_txn(r, "rst_in_w_cause", 3);

        for (int t = 0; t < 300; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            r.exc  = (kind != 1);
            r.eret = (kind != 0);
            r.en_s = $urandom; r.en_c = $urandom; r.en_e = $urandom; r.en_b = $urandom;
            r.inc  = $urandom;
            r.pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            r.bad  = $urandom; r.ns = $urandom; r.nc = $urandom; r.et = $urandom;
            r.cs   = $urandom; r.ce = $urandom;
            r.k    = $urandom_range(0, 3);
            run_txn(r, $sformatf("rand%0d", t), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
